uart_rx_deserializer: RTL
=========================

// Module: uart_rx_deserializer
// PURPOSE
//  Receive path of the UART. Oversamples the asynchronous rx pin at 16x the baud rate.
//  Detects and validates the start bit, then assembles 5..8 data bits LSB first.
//  Checks optional parity and 1 or 2 stop bits.
//  Each received character goes to the UART RX queue as a one-cycle write strobe with its error flags.
//  Sits between the rx pin and the RX FIFO write port.
//  It is timed by the UART's 16x-baud main clock-enable strobe.
// PARAMETERS
//  OVERSAMPLE  16  ticks per bit; must be a power of 2, >= 8
// PORTS
//  clk               in   1  system clock
//  reset             in   1  asynchronous, active-low reset
//  sample_tick       in   1  1-cycle enable at OVERSAMPLE x baud; FSM advances only on it
//  rx                in   1  asynchronous serial input, idle high
//  data_bits_count   in   2  data bits = value + 5 (5..8)
//  parity_type       in   2  00 none, 01 even, 10 odd, 11 none
//  double_stop_bits  in   1  1 = two stop bits expected
//  dout              out  8  received character, right-justified, unused MSBs 0
//  dout_valid        out  1  1-cycle pulse; dout/flags valid; drives RX FIFO we
//  parity_error      out  1  qualifies dout_valid: parity mismatch on this character
//  frame_error       out  1  qualifies dout_valid: a stop bit sampled low
//  busy              out  1  high whenever state != IDLE
// BEHAVIOUR
//  - reset low: state IDLE, synchronizer to 1, all counters 0, all outputs 0. Effective mid-frame; partial char discarded.
//  - rx passes a 2-FF synchronizer; rx_s is its output. rx_prev = rx_s latched on each sample_tick.
//  - Bit counter cnt (4b) increments on each tick. Wraps 15->0 at each state change in START/DATA/PARITY/STOP1.
//  - Bit decision = majority of rx_s taken at cnt 7, 8, 9; evaluated at cnt 9.
//  - IDLE -> START on a tick where rx_prev=1 and rx_s=0. That tick is cnt 0 of START.
//    Config inputs are latched here and are ignored for the rest of the frame.
//  - START: if majority=1 at cnt 9 -> IDLE (false start, no output). Else at cnt 15 -> DATA.
//  - DATA: shift the decided bit into an 8b shift register from the MSB side, every cnt 9.
//    After N bits (cnt 15) -> PARITY if parity enabled, else STOP1.
//    dout = shreg >> (8-N).
//  - PARITY: even => XOR(data, parity bit) must be 0; odd => must be 1. At cnt 15 -> STOP1.
//  - STOP1: at cnt 9, bit=0 sets frame_error.
//    If 2 stop bits, wait to cnt 15 -> STOP2. Else emit and go to IDLE at cnt 9 (half-bit early, allows resync).
//  - STOP2: at cnt 9, bit=0 sets frame_error; emit; go to IDLE.
//  - Emit: dout_valid=1 for exactly one clk; dout/parity_error/frame_error are registered and held until the next emit.
//    The character is emitted even with errors; no backpressure exists (a full FIFO drops it).
//  - Latency 8N1: dout_valid in the cycle after the tick with index 153, counted from the start-detect tick (16+8*16+9).
//  - Break (rx held low): emits dout=0, frame_error=1 once. No new start until rx seen high (edge detect).
//  - sample_tick low: all FSM/counter state holds. The synchronizer runs every clk.
// STRUCTURE
//  - uart_pkg: rx_state_t enum {IDLE,START,DATA,PARITY,STOP1,STOP2}, parity_t enum, uart_frame_cfg_t struct.
//    config_b layout is shared with the register block.
//  - One sub-module: bit_sync (2-FF synchronizer, reset value parameter = 1).
// TESTING (sample_tick=1 every clk unless stated)
//  1. 8N1 frame 0xA5 -> one dout_valid, dout=0xA5, no errors, 153 ticks after start detect.
//  2. 7E1 0x41 with parity bit sent as 1 (wrong) -> dout=0x41, parity_error=1; resend with correct bit 0 -> errors clear.
//  3. 5O2 0x15, second stop bit driven 0 -> dout=0x15, frame_error=1, parity_error=0.
//  4. rx low for 4 ticks then high -> no dout_valid, busy back to 0 by tick 10.
//     1-tick glitch at cnt 8 of a data bit -> byte still correct.
//  5. rx low 300 ticks -> exactly one dout_valid, dout=0x00, frame_error=1. 0x3C after rx returns high -> received OK.
//  6. reset asserted mid-DATA -> outputs 0 immediately. Next 8N1 0x7E frame received correctly.
//     Repeat test 1 with sample_tick every 5th clk -> same result.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, frame configuration layout and small helpers
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } rx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_t;

    // Field order matches the config_b register image.
    typedef struct packed {
        logic       double_stop;
        parity_t    parity;
        logic [1:0] data_bits;
    } uart_frame_cfg_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_enabled(input parity_t p);
        return (p == PAR_EVEN) || (p == PAR_ODD);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - two-flop synchronizer for a single asynchronous input bit
module bit_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - oversampled UART receiver feeding the RX queue write port
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic       rx,
    input  logic [1:0] data_bits_count,
    input  logic [1:0] parity_type,
    input  logic       double_stop_bits,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       parity_error,
    output logic       frame_error,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_S0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] CNT_DEC  = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

    logic            rx_s;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      samp_q, samp_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [2:0]      bitn_q, bitn_d;
    uart_frame_cfg_t cfg_q, cfg_d;
    logic            rx_prev_q, rx_prev_d;
    logic            perr_acc_q, perr_acc_d;
    logic            ferr_acc_q, ferr_acc_d;
    logic [7:0]      dout_q, dout_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            valid_q, valid_d;

    logic            start_edge;
    logic            bit_maj;
    logic            at_dec;
    logic            at_last;
    logic            last_data_bit;
    logic            emit;
    logic [1:0]      drop_bits;

    bit_sync #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk_i (clk),
        .rst_ni(reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    assign start_edge    = rx_prev_q & ~rx_s;
    assign bit_maj       = maj3(samp_q[0], samp_q[1], rx_s);
    assign at_dec        = (cnt_q == CNT_DEC);
    assign at_last       = (cnt_q == CNT_LAST);
    assign last_data_bit = (bitn_q == (3'd4 + {1'b0, cfg_q.data_bits}));
    assign drop_bits     = 2'd3 - cfg_q.data_bits;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            samp_q     <= '0;
            shreg_q    <= '0;
            bitn_q     <= '0;
            cfg_q      <= '0;
            rx_prev_q  <= 1'b1;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            dout_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            samp_q     <= samp_d;
            shreg_q    <= shreg_d;
            bitn_q     <= bitn_d;
            cfg_q      <= cfg_d;
            rx_prev_q  <= rx_prev_d;
            perr_acc_q <= perr_acc_d;
            ferr_acc_q <= ferr_acc_d;
            dout_q     <= dout_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin : next_state_comb
        state_d = state_q;
        if (sample_tick) begin
            unique case (state_q)
                IDLE:   if (start_edge) state_d = START;
                START: begin
                    if (at_dec && bit_maj) state_d = IDLE;
                    else if (at_last)      state_d = DATA;
                end
                DATA: begin
                    if (at_last && last_data_bit)
                        state_d = parity_enabled(cfg_q.parity) ? PARITY : STOP1;
                end
                PARITY: if (at_last) state_d = STOP1;
                // A single stop bit hands back to IDLE half a bit early so the next start edge is caught.
                STOP1: begin
                    if (cfg_q.double_stop) begin
                        if (at_last) state_d = STOP2;
                    end else if (at_dec) begin
                        state_d = IDLE;
                    end
                end
                STOP2:  if (at_dec) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin : datapath_comb
        cnt_d      = cnt_q;
        samp_d     = samp_q;
        shreg_d    = shreg_q;
        bitn_d     = bitn_q;
        cfg_d      = cfg_q;
        rx_prev_d  = rx_prev_q;
        perr_acc_d = perr_acc_q;
        ferr_acc_d = ferr_acc_q;
        dout_d     = dout_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        valid_d    = 1'b0;
        emit       = 1'b0;
        if (sample_tick) begin
            rx_prev_d = rx_s;
            if (cnt_q == CNT_S0) samp_d[0] = rx_s;
            if (cnt_q == CNT_S1) samp_d[1] = rx_s;

            // The detect tick itself is count 0 of START, so the next tick is count 1.
            if (state_q == IDLE) begin
                cnt_d = start_edge ? CW'(1) : '0;
            end else if (state_d == IDLE) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end

            unique case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        cfg_d = '{double_stop: double_stop_bits,
                                  parity:      parity_t'(parity_type),
                                  data_bits:   data_bits_count};
                        shreg_d    = '0;
                        bitn_d     = '0;
                        perr_acc_d = 1'b0;
                        ferr_acc_d = 1'b0;
                    end
                end
                START: ;
                DATA: begin
                    if (at_dec) shreg_d = {bit_maj, shreg_q[7:1]};
                    if (at_last && !last_data_bit) bitn_d = bitn_q + 3'd1;
                end
                PARITY: begin
                    if (at_dec)
                        perr_acc_d = ((^shreg_q) ^ bit_maj) != (cfg_q.parity == PAR_ODD);
                end
                STOP1: begin
                    if (at_dec) begin
                        if (!bit_maj) ferr_acc_d = 1'b1;
                        emit = !cfg_q.double_stop;
                    end
                end
                STOP2:   emit = at_dec;
                default: ;
            endcase

            if (emit) begin
                valid_d = 1'b1;
                dout_d  = shreg_q >> drop_bits;
                perr_d  = perr_acc_q;
                ferr_d  = ferr_acc_q | ~bit_maj;
            end
        end
    end

    always_comb begin : output_comb
        busy         = (state_q != IDLE);
        dout         = dout_q;
        dout_valid   = valid_q;
        parity_error = perr_q;
        frame_error  = ferr_q;
    end

endmodule
